// File: rtl/chrono_lap_timer_pkg.sv
// Shared types for the chronometer core:
// FSM states, count direction, lap address width.
package chrono_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int lap_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/chrono_lap_timer_if.sv
// Command and readout bundle of the chronometer.
// master drives commands, slave is the timer core.
interface chrono_lap_timer_if #(
    parameter int CNT_W     = 16,
    parameter int LAP_DEPTH = 8
);
    import chrono_pkg::*;

    localparam int LAP_AW = lap_aw(LAP_DEPTH);

    logic             start_i;
    logic             stop_i;
    logic             clear_i;
    logic             lap_i;
    logic             dir_i;
    logic             load_i;
    logic [CNT_W-1:0] load_val_i;
    logic             lap_rd_i;
    logic [CNT_W-1:0] value_o;
    logic             running_o;
    logic             expired_o;
    logic [CNT_W-1:0] lap_data_o;
    logic             lap_empty_o;
    logic             lap_full_o;
    logic [LAP_AW:0]  lap_cnt_o;
    logic             lap_ovf_o;

    modport master (
        output start_i, stop_i, clear_i, lap_i,
        output dir_i, load_i, load_val_i, lap_rd_i,
        input  value_o, running_o, expired_o,
        input  lap_data_o, lap_empty_o, lap_full_o,
        input  lap_cnt_o, lap_ovf_o
    );

    modport slave (
        input  start_i, stop_i, clear_i, lap_i,
        input  dir_i, load_i, load_val_i, lap_rd_i,
        output value_o, running_o, expired_o,
        output lap_data_o, lap_empty_o, lap_full_o,
        output lap_cnt_o, lap_ovf_o
    );

endinterface

// File: rtl/chrono_lap_timer_fifo.sv
// First-word fall-through lap FIFO with flush
// and a sticky flag for pushes dropped while full.
module chrono_lap_fifo
    import chrono_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = lap_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      cnt_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             ovf_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign cnt_o   = cnt_q;
    assign ovf_o   = ovf_q;

    // Storage write; contents are don't-care until counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i)
            mem_q[wr_q] <= data_i;
    end

    // Pointers, occupancy and overflow; flush beats push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push)
                wr_q <= wr_q + 1'b1;
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (push_i && full_o && !do_pop)
                ovf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/chrono_lap_timer.sv
// Up/down chronometer core with prescaler and lap FIFO.
// Define CHRONO_SPLIT_EN to store split times in the FIFO.
module chrono_lap_timer
    import chrono_pkg::*;
#(
    parameter  int CNT_W     = 16,
    parameter  int PRESCALE  = 5000000,
    parameter  int LAP_DEPTH = 8,
    localparam int LAP_AW    = lap_aw(LAP_DEPTH)
) (
    input logic clk,
    input logic rst,
    chrono_lap_timer_if.slave bus
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    state_e           state_q;
    logic [PS_W-1:0]  presc_q;
    logic [CNT_W-1:0] value_q;
    logic             dir_q;
    logic             exp_q;
    logic             tick;
    logic             start_ok;
    logic             lap_push;
    logic             lap_full;
    logic             push_ok;
    logic [CNT_W-1:0] lap_wdata;

    assign tick     = (state_q == ST_RUN) && (presc_q == PS_MAX);
    assign start_ok = !(bus.dir_i == DIR_DOWN && value_q == '0);

    assign bus.value_o   = value_q;
    assign bus.running_o = (state_q == ST_RUN);
    assign bus.expired_o = exp_q;

    // Run/pause/idle control, prescaler and time value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            value_q <= '0;
            dir_q   <= DIR_UP;
            exp_q   <= 1'b0;
        end else begin
            exp_q <= 1'b0;
            if (bus.clear_i) begin
                state_q <= ST_IDLE;
                presc_q <= '0;
                value_q <= '0;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (bus.stop_i) begin
                            state_q <= ST_PAUSE;
                        end else if (tick) begin
                            presc_q <= '0;
                            if (dir_q == DIR_UP) begin
                                value_q <= value_q + 1'b1;
                            end else begin
                                value_q <= value_q - 1'b1;
                                if (value_q == CNT_W'(1)) begin
                                    exp_q   <= 1'b1;
                                    state_q <= ST_PAUSE;
                                end
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    ST_IDLE, ST_PAUSE: begin
                        if (bus.stop_i) begin
                            state_q <= state_q;
                        end else if (bus.start_i) begin
                            if (start_ok) begin
                                state_q <= ST_RUN;
                                dir_q   <= bus.dir_i;
                            end
                        end else if (bus.load_i) begin
                            value_q <= bus.load_val_i;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign lap_push = bus.lap_i && (state_q != ST_IDLE);
    assign push_ok  = lap_push && !bus.clear_i
                   && (!lap_full || bus.lap_rd_i);
    assign bus.lap_full_o = lap_full;

`ifdef CHRONO_SPLIT_EN
    logic [CNT_W-1:0] last_q;

    assign lap_wdata = value_q - last_q;

    // Reference for split times; only accepted laps move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= '0;
        else if (bus.clear_i)
            last_q <= '0;
        else if (push_ok)
            last_q <= value_q;
    end
`else
    assign lap_wdata = value_q;
`endif

    chrono_lap_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (LAP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.clear_i),
        .push_i  (lap_push),
        .pop_i   (bus.lap_rd_i),
        .data_i  (lap_wdata),
        .data_o  (bus.lap_data_o),
        .empty_o (bus.lap_empty_o),
        .full_o  (lap_full),
        .cnt_o   (bus.lap_cnt_o),
        .ovf_o   (bus.lap_ovf_o)
    );

endmodule

// File: tb/tb_chrono_lap_timer.sv
// Directed bench for chrono_lap_timer with a cycle model
// of the timer and a queue model of the lap FIFO.
module tb_chrono_lap_timer;
    import chrono_pkg::*;

    localparam int W  = 8;
    localparam int PS = 4;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chrono_lap_timer_if #(.CNT_W(W), .LAP_DEPTH(D)) bus();

    chrono_lap_timer #(
        .CNT_W     (W),
        .PRESCALE  (PS),
        .LAP_DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     nm, $time, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at the last posedge.
    logic         s_rst = 1'b1;
    logic         s_start = 0, s_stop = 0, s_clr = 0, s_lap = 0;
    logic         s_rd = 0, s_load = 0, s_dir = 0;
    logic [W-1:0] s_lv = '0;

    always @(posedge clk) begin
        s_rst   <= rst;
        s_start <= bus.start_i;
        s_stop  <= bus.stop_i;
        s_clr   <= bus.clear_i;
        s_lap   <= bus.lap_i;
        s_rd    <= bus.lap_rd_i;
        s_load  <= bus.load_i;
        s_dir   <= bus.dir_i;
        s_lv    <= bus.load_val_i;
    end

    // Model: mode 0 idle, 1 run, 2 pause; phase = clocks into a tick.
    int           m_mode  = 0;
    int           m_phase = 0;
    logic [W-1:0] m_val   = '0;
    logic [W-1:0] m_last  = '0;
    logic         m_dir   = 1'b0;
    logic         m_exp   = 1'b0;
    logic         m_ovf   = 1'b0;
    logic [W-1:0] m_q[$];

    task automatic model_step();
        bit full0;
        bit popok;
        bit pushreq;
        if (s_rst) begin
            m_mode = 0; m_phase = 0; m_val = '0; m_last = '0;
            m_dir = 0; m_exp = 0; m_ovf = 0; m_q.delete();
            return;
        end
        full0   = (m_q.size() == D);
        popok   = s_rd && (m_q.size() > 0);
        pushreq = s_lap && (m_mode != 0);
        m_exp   = 1'b0;
        if (s_clr) begin
            m_q.delete(); m_ovf = 0; m_last = '0;
        end else begin
            if (popok) void'(m_q.pop_front());
            if (pushreq) begin
                if (!full0 || popok) begin
`ifdef CHRONO_SPLIT_EN
                    m_q.push_back(m_val - m_last);
                    m_last = m_val;
`else
                    m_q.push_back(m_val);
`endif
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (s_clr) begin
            m_mode = 0; m_val = '0; m_phase = 0;
        end else if (m_mode == 1) begin
            if (s_stop) begin
                m_mode = 2;
            end else begin
                m_phase++;
                if (m_phase == PS) begin
                    m_phase = 0;
                    if (!m_dir) begin
                        m_val = m_val + 1'b1;
                    end else begin
                        if (m_val == 1) begin
                            m_exp = 1'b1;
                            m_mode = 2;
                        end
                        m_val = m_val - 1'b1;
                    end
                end
            end
        end else if (!s_stop) begin
            if (s_start) begin
                if (!(s_dir && m_val == 0)) begin
                    m_mode = 1; m_dir = s_dir;
                end
            end else if (s_load) begin
                m_val = s_lv;
            end
        end
    endtask

    // Compare process: every negedge, advance model and check.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("value", bus.value_o, m_val);
            chk("running", bus.running_o, (m_mode == 1));
            chk("expired", bus.expired_o, m_exp);
            chk("empty", bus.lap_empty_o, (m_q.size() == 0));
            chk("full", bus.lap_full_o, (m_q.size() == D));
            chk("cnt", bus.lap_cnt_o, m_q.size());
            chk("ovf", bus.lap_ovf_o, m_ovf);
            if (m_q.size() > 0)
                chk("lap_data", bus.lap_data_o, m_q[0]);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input bit st, input bit sp, input bit cl,
                       input bit lp, input bit rd, input bit ld,
                       input bit dr, input logic [W-1:0] lv);
        bus.start_i = st; bus.stop_i = sp; bus.clear_i = cl;
        bus.lap_i = lp; bus.lap_rd_i = rd; bus.load_i = ld;
        bus.dir_i = dr; bus.load_val_i = lv;
        @(negedge clk);
        bus.start_i = 0; bus.stop_i = 0; bus.clear_i = 0;
        bus.lap_i = 0; bus.lap_rd_i = 0; bus.load_i = 0;
        bus.dir_i = 0; bus.load_val_i = '0;
    endtask

    initial begin
        bus.start_i = 0; bus.stop_i = 0; bus.clear_i = 0;
        bus.lap_i = 0; bus.lap_rd_i = 0; bus.load_i = 0;
        bus.dir_i = 0; bus.load_val_i = '0;
        wait_n(3);
        rst = 1'b0;
        chk("rst_value", bus.value_o, 0);
        chk("rst_running", bus.running_o, 0);
        chk("rst_empty", bus.lap_empty_o, 1);
        chk("rst_cnt", bus.lap_cnt_o, 0);

        // Count up for 40 clocks, then pause mid-tick.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        wait_n(40);
        chk("up40_value", bus.value_o, 10);
        chk("up40_running", bus.running_o, 1);
        wait_n(2);
        cmd(0, 1, 0, 0, 0, 0, 0, 0);
        wait_n(20);
        chk("pause_value", bus.value_o, 10);
        chk("pause_running", bus.running_o, 0);
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        wait_n(1);
        chk("resume_pre", bus.value_o, 10);
        wait_n(1);
        chk("resume_tick", bus.value_o, 11);

        // Countdown from 3 to expiry.
        cmd(0, 0, 1, 0, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 0, 1, 0, 3);
        cmd(1, 0, 0, 0, 0, 0, 1, 0);
        wait_n(11);
        chk("down_pre", bus.value_o, 1);
        chk("down_pre_exp", bus.expired_o, 0);
        wait_n(1);
        chk("down_zero", bus.value_o, 0);
        chk("down_exp", bus.expired_o, 1);
        chk("down_paused", bus.running_o, 0);
        wait_n(1);
        chk("down_exp_pulse", bus.expired_o, 0);
        cmd(1, 0, 0, 0, 0, 0, 1, 0);
        chk("down_start_ign", bus.running_o, 0);

        // Five laps into a four-deep FIFO.
        cmd(0, 0, 1, 0, 0, 0, 0, 0);
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        wait_n(4);
        for (int k = 1; k <= 5; k++) begin
            cmd(0, 0, 0, 1, 0, 0, 0, 0);
            wait_n(3);
        end
        chk("lap_full", bus.lap_full_o, 1);
        chk("lap_cnt4", bus.lap_cnt_o, 4);
        chk("lap_ovf", bus.lap_ovf_o, 1);
        cmd(0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("lap_pop", bus.lap_data_o, k);
            cmd(0, 0, 0, 0, 1, 0, 0, 0);
        end
        chk("lap_drained", bus.lap_empty_o, 1);

        // Push and pop together on a full FIFO, then clear+lap.
        cmd(0, 0, 1, 0, 0, 0, 0, 0);
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        wait_n(4);
        for (int k = 1; k <= 4; k++) begin
            cmd(0, 0, 0, 1, 0, 0, 0, 0);
            wait_n(3);
        end
        chk("pp_full", bus.lap_full_o, 1);
        cmd(0, 0, 0, 1, 1, 0, 0, 0);
        chk("pp_cnt", bus.lap_cnt_o, 4);
        chk("pp_ovf", bus.lap_ovf_o, 0);
        chk("pp_head", bus.lap_data_o, 2);
        cmd(0, 0, 1, 1, 0, 0, 0, 0);
        chk("clr_empty", bus.lap_empty_o, 1);
        chk("clr_value", bus.value_o, 0);
        chk("clr_idle", bus.running_o, 0);

`ifdef CHRONO_SPLIT_EN
        // Split laps at 5, 12, 20.
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        wait_n(20);
        cmd(0, 0, 0, 1, 0, 0, 0, 0);
        wait_n(27);
        cmd(0, 0, 0, 1, 0, 0, 0, 0);
        wait_n(31);
        cmd(0, 0, 0, 1, 0, 0, 0, 0);
        cmd(0, 1, 0, 0, 0, 0, 0, 0);
        chk("split0", bus.lap_data_o, 5);
        cmd(0, 0, 0, 0, 1, 0, 0, 0);
        chk("split1", bus.lap_data_o, 7);
        cmd(0, 0, 0, 0, 1, 0, 0, 0);
        chk("split2", bus.lap_data_o, 8);
        cmd(0, 0, 0, 0, 1, 0, 0, 0);
        cmd(0, 0, 1, 0, 0, 0, 0, 0);
`endif

        // Up-count wrap from 255 to 0 raises no expiry.
        cmd(0, 0, 0, 0, 0, 1, 0, 254);
        cmd(1, 0, 0, 0, 0, 0, 0, 0);
        wait_n(4);
        chk("wrap_255", bus.value_o, 255);
        wait_n(4);
        chk("wrap_0", bus.value_o, 0);
        chk("wrap_run", bus.running_o, 1);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_noexp", bus.expired_o, 0);
            wait_n(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chrono_lap_timer.md
Name: chrono_lap_timer

Overview:
Second-generation chronometer core: parametrised-width up/down stopwatch/countdown timer with a programmable prescaler and an on-chip lap FIFO. Sits between the debounced button/command logic and the display/readout path. Replaces the single-slot stop/resume capture with multi-entry lap storage, preload, and countdown expiry.

Parameters:
CNT_W, 16, width of the time value in ticks.
PRESCALE, 5000000, clk cycles per tick; must be >= 2.
LAP_DEPTH, 8, lap FIFO entries; must be a power of two.
LAP_AW, $clog2(LAP_DEPTH), lap FIFO address width (derived, not overridden).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start_i  in  1  start/resume pulse (debounced, one cycle)
stop_i  in  1  pause pulse
clear_i  in  1  clear pulse: return to IDLE, zero value, flush FIFO
lap_i  in  1  capture current value into lap FIFO
dir_i  in  1  0 = count up, 1 = count down; sampled only on accepted start
load_i  in  1  preload value_o from load_val_i
load_val_i  in  CNT_W  preload value
lap_rd_i  in  1  pop lap FIFO head
value_o  out  CNT_W  current time value (registered)
running_o  out  1  high in RUN
expired_o  out  1  one-cycle pulse when countdown reaches 0
lap_data_o  out  CNT_W  FIFO head (first-word fall-through)
lap_empty_o  out  1  FIFO empty
lap_full_o  out  1  FIFO full
lap_cnt_o  out  LAP_AW+1  entries held
lap_ovf_o  out  1  sticky: a lap was dropped while full

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock. State IDLE, value_o=0, prescaler=0, dir=up, running_o=0, expired_o=0, FIFO empty (lap_empty_o=1, lap_full_o=0, lap_cnt_o=0), lap_ovf_o=0. Reset mid-count discards everything.
- States: IDLE, RUN, PAUSE. All commands are sampled at posedge; effects visible the next cycle.
- Same-cycle command priority: clear > stop > start > load. lap_i is independent and captures value_o as held before that edge.
- IDLE: start -> RUN (latch dir_i); load -> value_o=load_val_i.
- RUN: prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and issues a tick. stop -> PAUSE; clear -> IDLE; start and load are ignored.
- PAUSE: prescaler holds its value, so the fractional tick is preserved on resume. start -> RUN (re-latch dir_i); load -> value_o=load_val_i; clear -> IDLE.
- Entering IDLE via clear: value_o=0, prescaler=0, FIFO flushed, lap_ovf_o cleared.
- Up tick: value_o+1, wrapping 2^CNT_W-1 -> 0 with no flag.
- Down tick:
  - value_o-1.
  - On the tick that takes value 1 -> 0: expired_o pulses one cycle, state -> PAUSE, prescaler -> 0.
- start in down mode with value_o==0 is ignored; state is unchanged.
- Lap FIFO:
  - lap_i in RUN or PAUSE pushes value_o. lap_i in IDLE is ignored.
  - A push while full is dropped and sets lap_ovf_o, unless lap_rd_i pops in the same cycle; then both occur.
  - lap_rd_i while empty is ignored.
  - Push and pop in the same cycle on a non-empty FIFO leave lap_cnt_o unchanged.
  - lap_data_o is valid whenever lap_empty_o=0. Pointers wrap modulo LAP_DEPTH.
  - clear in the same cycle as lap_i or lap_rd_i: clear wins and the FIFO ends empty.

Optional Feature:
CHRONO_SPLIT_EN.
- Defined: each lap entry stores the split, i.e. value_o minus the value of the previous accepted lap (modulo 2^CNT_W). The first lap after IDLE is relative to 0. A last-lap register holds the reference; clear zeroes it; dropped laps do not update it.
- Undefined: entries hold absolute value_o and no last-lap register exists.

Decomposition:
- Package chrono_pkg holds:
  - the state encoding (IDLE/RUN/PAUSE);
  - the direction constants DIR_UP/DIR_DOWN;
  - a function computing the LAP_AW width.
- Sub-module chrono_lap_fifo (params WIDTH, DEPTH) holds storage, pointers, count, full/empty and overflow. Its interface is push/pop/flush.
- Top level holds the FSM, prescaler and value arithmetic.

Test Plan (PRESCALE=4, CNT_W=8, LAP_DEPTH=4):
- Reset, start up, run 40 clk -> value_o=10, running_o=1; stop -> value_o frozen at 10 for 20 clk.
- Stop at prescaler=2, then start -> first tick 2 clk after resume; value 10 -> 11.
- load 3 in IDLE, start with dir_i=1 -> after 12 clk value_o=0, expired_o high exactly one cycle, state PAUSE; further start ignored.
- 5 laps at values 1,2,3,4,5 with no reads -> lap_full_o=1, lap_cnt_o=4, lap_ovf_o=1; pops return 1,2,3,4.
- Full FIFO with lap_i and lap_rd_i in the same cycle -> lap_cnt_o stays 4, no overflow; clear together with lap_i -> FIFO empty, value_o=0, IDLE.
- CHRONO_SPLIT_EN: laps at 5, 12, 20 -> FIFO holds 5, 7, 8. Up-count wrap 255 -> 0 produces no expired_o.
